// File: rtl/vs_result_buffer_if.sv
// Port bundle of the value-similarity result buffer: allocation, writeback,
// pickup and pointer-invalidation channels plus occupancy status.
interface vs_result_buffer_if #(
    parameter int RESULT_BUFFER_SIZE = 8,
    parameter int RB_ID_W            = $clog2(RESULT_BUFFER_SIZE),
    parameter int PTR_ID_W           = 5,
    parameter int DATA_W             = 32
);
    logic                alloc_req;
    logic [PTR_ID_W-1:0] alloc_ptr_id;
    logic                alloc_grant;
    logic [RB_ID_W-1:0]  alloc_idx;

    logic                wr_en;
    logic [RB_ID_W-1:0]  wr_idx;
    logic [DATA_W-1:0]   wr_result;
    logic                wr_err;

    logic                pick_en;
    logic [RB_ID_W-1:0]  pick_idx;
    logic                pick_done;
    logic                pick_hit;
    logic [DATA_W-1:0]   pick_result;

    logic                inval_en;
    logic [PTR_ID_W-1:0] inval_ptr_id;

    logic [RB_ID_W:0]    count;
    logic                full;
    logic                empty;

    modport master (
        output alloc_req, alloc_ptr_id, wr_en, wr_idx, wr_result,
               pick_en, pick_idx, inval_en, inval_ptr_id,
        input  alloc_grant, alloc_idx, wr_err, pick_done, pick_hit,
               pick_result, count, full, empty
    );

    modport slave (
        input  alloc_req, alloc_ptr_id, wr_en, wr_idx, wr_result,
               pick_en, pick_idx, inval_en, inval_ptr_id,
        output alloc_grant, alloc_idx, wr_err, pick_done, pick_hit,
               pick_result, count, full, empty
    );
endinterface

// File: rtl/vs_result_buffer.sv
// Result buffer of the value-similarity skip path: per-entry FREE/PENDING/VALID
// tracking with lowest-free allocation, writeback, consuming pickup and tag flush.
module vs_result_buffer #(
    parameter int RESULT_BUFFER_SIZE = 8,
    parameter int RB_ID_W            = $clog2(RESULT_BUFFER_SIZE),
    parameter int PTR_ID_W           = 5,
    parameter int DATA_W             = 32
) (
    input  logic               clk,
    input  logic               reset,
    vs_result_buffer_if.slave  bus
);
    localparam int N = RESULT_BUFFER_SIZE;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_VALID   = 2'd2
    } entry_state_t;

    entry_state_t        state_r  [N];
    entry_state_t        state_s  [N];
    logic [DATA_W-1:0]   result_r [N];
    logic [DATA_W-1:0]   result_s [N];
    logic [PTR_ID_W-1:0] ptr_r    [N];
    logic [PTR_ID_W-1:0] ptr_s    [N];

    logic [N-1:0]        free_s;
    logic [N-1:0]        pending_s;
    logic [N-1:0]        inval_hit_s;
    logic [N-1:0]        pick_hit_s;
    logic [N-1:0]        wr_sel_s;
    logic [N-1:0]        alloc_sel_s;
    logic [N-1:0]        occupied_next_s;

    logic                full_s;
    logic                empty_s;
    logic                alloc_grant_s;
    logic [RB_ID_W-1:0]  alloc_idx_s;
    logic                wr_err_s;
    logic                stage_hit_s;
    logic [DATA_W-1:0]   stage_result_s;

    logic [RB_ID_W:0]    count_r;
    logic                wr_err_r;
    logic                stage_valid_r;
    logic                stage_hit_r;
    logic [DATA_W-1:0]   stage_result_r;
    logic                pick_done_r;
    logic                pick_hit_r;
    logic [DATA_W-1:0]   pick_result_r;

    function automatic logic [RB_ID_W:0] popcount(input logic [N-1:0] vec);
        logic [RB_ID_W:0] acc;
        acc = {(RB_ID_W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            acc = acc + {{RB_ID_W{1'b0}}, vec[i]};
        end
        return acc;
    endfunction

    // Per-entry event decode from start-of-cycle state (FSM output process).
    always_comb begin
        full_s        = (count_r == (RB_ID_W+1)'(N));
        empty_s       = (count_r == {(RB_ID_W+1){1'b0}});
        alloc_grant_s = bus.alloc_req & ~full_s;
        alloc_idx_s   = {RB_ID_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (state_r[i] == ST_FREE) begin
                alloc_idx_s = RB_ID_W'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            free_s[i]      = (state_r[i] == ST_FREE);
            pending_s[i]   = (state_r[i] == ST_PENDING);
            inval_hit_s[i] = bus.inval_en & ~free_s[i] & (ptr_r[i] == bus.inval_ptr_id);
            pick_hit_s[i]  = bus.pick_en & (bus.pick_idx == RB_ID_W'(i))
                             & (state_r[i] == ST_VALID) & ~inval_hit_s[i];
            wr_sel_s[i]    = bus.wr_en & (bus.wr_idx == RB_ID_W'(i));
            alloc_sel_s[i] = alloc_grant_s & (alloc_idx_s == RB_ID_W'(i));
        end
        // A write is only legal against a PENDING entry; anything else is flagged.
        wr_err_s       = bus.wr_en & ~(|(wr_sel_s & pending_s));
        stage_hit_s    = |pick_hit_s;
        stage_result_s = {DATA_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (pick_hit_s[i]) begin
                stage_result_s = stage_result_s | result_r[i];
            end else begin
                stage_result_s = stage_result_s;
            end
        end
    end

    // Next-state and next-data per entry; invalidate > pickup > write > alloc.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_s[i]  = state_r[i];
            result_s[i] = result_r[i];
            ptr_s[i]    = ptr_r[i];
            case (state_r[i])
                ST_FREE: begin
                    if (alloc_sel_s[i]) begin
                        state_s[i]  = ST_PENDING;
                        ptr_s[i]    = bus.alloc_ptr_id;
                        result_s[i] = {DATA_W{1'b0}};
                    end else begin
                        state_s[i]  = ST_FREE;
                    end
                end
                ST_PENDING: begin
                    if (inval_hit_s[i]) begin
                        state_s[i]  = ST_FREE;
                    end else if (wr_sel_s[i]) begin
                        state_s[i]  = ST_VALID;
                        result_s[i] = bus.wr_result;
                    end else begin
                        state_s[i]  = ST_PENDING;
                    end
                end
                ST_VALID: begin
                    if (inval_hit_s[i] || pick_hit_s[i]) begin
                        state_s[i]  = ST_FREE;
                    end else begin
                        state_s[i]  = ST_VALID;
                    end
                end
                default: begin
                    state_s[i]  = ST_FREE;
                end
            endcase
            occupied_next_s[i] = (state_s[i] != ST_FREE);
        end
    end

    // Entry state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                state_r[i]  <= ST_FREE;
                result_r[i] <= {DATA_W{1'b0}};
                ptr_r[i]    <= {PTR_ID_W{1'b0}};
            end else begin
                state_r[i]  <= state_s[i];
                result_r[i] <= result_s[i];
                ptr_r[i]    <= ptr_s[i];
            end
        end
    end

    // Occupancy, write error and the two-stage pickup response pipeline.
    // The response is held one stage so a reset on the following edge squashes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r        <= {(RB_ID_W+1){1'b0}};
            wr_err_r       <= 1'b0;
            stage_valid_r  <= 1'b0;
            stage_hit_r    <= 1'b0;
            stage_result_r <= {DATA_W{1'b0}};
            pick_done_r    <= 1'b0;
            pick_hit_r     <= 1'b0;
            pick_result_r  <= {DATA_W{1'b0}};
        end else begin
            count_r        <= popcount(occupied_next_s);
            wr_err_r       <= wr_err_s;
            stage_valid_r  <= bus.pick_en;
            stage_hit_r    <= stage_hit_s;
            stage_result_r <= stage_result_s;
            pick_done_r    <= stage_valid_r;
            pick_hit_r     <= stage_valid_r & stage_hit_r;
            pick_result_r  <= (stage_valid_r & stage_hit_r) ? stage_result_r : {DATA_W{1'b0}};
        end
    end

    assign bus.alloc_grant = alloc_grant_s;
    assign bus.alloc_idx   = alloc_idx_s;
    assign bus.wr_err      = wr_err_r;
    assign bus.pick_done   = pick_done_r;
    assign bus.pick_hit    = pick_hit_r;
    assign bus.pick_result = pick_result_r;
    assign bus.count       = count_r;
    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
endmodule

// File: tb/tb_vs_result_buffer.sv
// Directed bench for vs_result_buffer: pickup responses go through a scoreboard
// queue checked by an independent monitor; other outputs are checked inline.
module tb_vs_result_buffer;
    localparam int SIZE = 8;
    localparam int IDW  = 3;
    localparam int PW   = 5;
    localparam int DW   = 32;

    logic clk;
    logic reset;

    vs_result_buffer_if #(.RESULT_BUFFER_SIZE(SIZE), .RB_ID_W(IDW), .PTR_ID_W(PW), .DATA_W(DW)) bus ();

    vs_result_buffer #(.RESULT_BUFFER_SIZE(SIZE), .RB_ID_W(IDW), .PTR_ID_W(PW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        hit;
        logic [31:0] res;
    } pick_exp_t;

    pick_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req    = 1'b0;
        bus.alloc_ptr_id = 5'd0;
        bus.wr_en        = 1'b0;
        bus.wr_idx       = 3'd0;
        bus.wr_result    = 32'd0;
        bus.pick_en      = 1'b0;
        bus.pick_idx     = 3'd0;
        bus.inval_en     = 1'b0;
        bus.inval_ptr_id = 5'd0;
    endtask

    task automatic pick(input logic [2:0] idx, input logic hit, input logic [31:0] res);
        pick_exp_t e;
        e.hit = hit;
        e.res = res;
        exp_q.push_back(e);
        bus.pick_en  = 1'b1;
        bus.pick_idx = idx;
    endtask

    task automatic alloc_chk(input logic [4:0] tag, input logic [2:0] exp_idx, input string name);
        bus.alloc_req    = 1'b1;
        bus.alloc_ptr_id = tag;
        #1;
        chk({name, "_grant"}, {31'd0, bus.alloc_grant}, 32'd1);
        chk({name, "_idx"}, {29'd0, bus.alloc_idx}, {29'd0, exp_idx});
    endtask

    // Scoreboard monitor: every pick_done pops one expected response.
    always @(negedge clk) begin
        if (bus.pick_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pick_unexpected: got pick_done=1, expected no response");
            end else begin
                pick_exp_t e;
                e = exp_q.pop_front();
                chk("pick_hit", {31'd0, bus.pick_hit}, {31'd0, e.hit});
                chk("pick_result", bus.pick_result, e.res);
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_count", {28'd0, bus.count}, 32'd0);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_full", {31'd0, bus.full}, 32'd0);
        chk("rst_pick_done", {31'd0, bus.pick_done}, 32'd0);
        chk("rst_pick_hit", {31'd0, bus.pick_hit}, 32'd0);
        chk("rst_pick_result", bus.pick_result, 32'd0);
        chk("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);
        chk("rst_grant", {31'd0, bus.alloc_grant}, 32'd0);

        // Fill all eight entries, then a ninth request is refused.
        for (int k = 0; k < SIZE; k++) begin
            tick();
            alloc_chk(5'(k + 1), 3'(k), "fill");
        end
        tick();
        bus.alloc_ptr_id = 5'd9;
        #1;
        chk("fill_full", {31'd0, bus.full}, 32'd1);
        chk("fill_count", {28'd0, bus.count}, 32'd8);
        chk("fill_9th_grant", {31'd0, bus.alloc_grant}, 32'd0);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Alloc / write / pickup round trip, then repeat pickup misses.
        alloc_chk(5'd3, 3'd0, "rt_alloc");
        tick();
        idle();
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'd0;
        bus.wr_result = 32'hDEADBEEF;
        tick();
        chk("rt_count1", {28'd0, bus.count}, 32'd1);
        idle();
        pick(3'd0, 1'b1, 32'hDEADBEEF);
        tick();
        chk("rt_count0", {28'd0, bus.count}, 32'd0);
        chk("rt_wr_err", {31'd0, bus.wr_err}, 32'd0);
        pick(3'd0, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        tick();

        // Pickup of a PENDING entry in the same cycle as its write.
        alloc_chk(5'd10, 3'd0, "pend_a0");
        tick();
        alloc_chk(5'd11, 3'd1, "pend_a1");
        tick();
        alloc_chk(5'd12, 3'd2, "pend_a2");
        tick();
        idle();
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'd2;
        bus.wr_result = 32'h12345678;
        pick(3'd2, 1'b0, 32'd0);
        tick();
        idle();
        pick(3'd2, 1'b1, 32'h12345678);
        tick();
        idle();
        chk("pend_count", {28'd0, bus.count}, 32'd2);
        bus.inval_en     = 1'b1;
        bus.inval_ptr_id = 5'd10;
        tick();
        bus.inval_ptr_id = 5'd11;
        tick();
        idle();
        chk("pend_flush_count", {28'd0, bus.count}, 32'd0);
        chk("pend_flush_empty", {31'd0, bus.empty}, 32'd1);

        // Invalidate by tag 5 frees idx0 and idx2, leaves idx1.
        alloc_chk(5'd5, 3'd0, "inv_a0");
        tick();
        alloc_chk(5'd7, 3'd1, "inv_a1");
        tick();
        alloc_chk(5'd5, 3'd2, "inv_a2");
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.wr_en     = 1'b1;
            bus.wr_idx    = 3'(k);
            bus.wr_result = 32'hA0 + 32'(k);
            tick();
        end
        idle();
        chk("inv_wr_err", {31'd0, bus.wr_err}, 32'd0);
        bus.inval_en     = 1'b1;
        bus.inval_ptr_id = 5'd5;
        tick();
        idle();
        chk("inv_count", {28'd0, bus.count}, 32'd1);
        pick(3'd1, 1'b1, 32'hA1);
        alloc_chk(5'd9, 3'd0, "inv_realloc");
        tick();
        idle();
        chk("inv_count2", {28'd0, bus.count}, 32'd1);

        // Write to a FREE entry flags wr_err and changes nothing.
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'd4;
        bus.wr_result = 32'h55;
        tick();
        idle();
        chk("err_free_wr_err", {31'd0, bus.wr_err}, 32'd1);
        chk("err_free_count", {28'd0, bus.count}, 32'd1);
        pick(3'd4, 1'b0, 32'd0);
        tick();
        idle();
        chk("err_clear", {31'd0, bus.wr_err}, 32'd0);
        // A VALID entry is never overwritten.
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'd0;
        bus.wr_result = 32'h77;
        tick();
        chk("err_ok_wr", {31'd0, bus.wr_err}, 32'd0);
        bus.wr_result = 32'h88;
        tick();
        idle();
        chk("err_valid_wr_err", {31'd0, bus.wr_err}, 32'd1);
        pick(3'd0, 1'b1, 32'h77);
        tick();
        idle();
        chk("err_valid_count", {28'd0, bus.count}, 32'd0);

        // Write and invalidate on the same PENDING entry.
        alloc_chk(5'd20, 3'd0, "wi_alloc");
        tick();
        idle();
        bus.wr_en        = 1'b1;
        bus.wr_idx       = 3'd0;
        bus.wr_result    = 32'h99;
        bus.inval_en     = 1'b1;
        bus.inval_ptr_id = 5'd20;
        tick();
        idle();
        chk("wi_wr_err", {31'd0, bus.wr_err}, 32'd0);
        chk("wi_count", {28'd0, bus.count}, 32'd0);
        pick(3'd0, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        tick();

        // Reset the cycle after a pickup of a VALID entry squashes the response.
        alloc_chk(5'd2, 3'd0, "rp_alloc");
        tick();
        idle();
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'd0;
        bus.wr_result = 32'hCAFE;
        tick();
        idle();
        bus.pick_en  = 1'b1;
        bus.pick_idx = 3'd0;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rp_pick_done", {31'd0, bus.pick_done}, 32'd0);
        chk("rp_count", {28'd0, bus.count}, 32'd0);
        chk("rp_empty", {31'd0, bus.empty}, 32'd1);
        tick();
        chk("rp_pick_done2", {31'd0, bus.pick_done}, 32'd0);
        tick();
        tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
